// File: rtl/orbtrace_pkg.sv
// Shared constants and types for the trace UART transmit path:
// packet header bytes, host command codes, trace width encodings and
// the scheduler state encoding.
package orbtrace_pkg;

  // Packet header bytes, one per source
  localparam logic [7:0] HDR_FRAME = 8'hA5;
  localparam logic [7:0] HDR_RESP  = 8'hA6;
  localparam logic [7:0] HDR_STAT  = 8'hA7;
  // Reply payload for an unknown or unsupported command
  localparam logic [7:0] NAK       = 8'hFF;

  // Upper nibble of a SET_WIDTH host command
  localparam logic [3:0] CMD_SET_WIDTH = 4'h5;

  // Trace port width encodings (00=1 bit, 01=2 bit, 10=4 bit, 11 invalid)
  localparam logic [1:0] WIDTH_1B   = 2'b00;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FRAME = 3'd2,
    ST_RESP  = 3'd3,
    ST_STAT  = 3'd4
  } state_t;

  // True when the command is a SET_WIDTH carrying a usable width
  function automatic logic is_valid_set_width(input logic [7:0] cmd);
    return (cmd[7:4] == CMD_SET_WIDTH) && (cmd[1:0] != WIDTH_RSVD);
  endfunction

endpackage

// File: rtl/led_stretch.sv
// Retriggerable pulse stretcher: the output stays high for LED_STRETCH
// cycles after the most recent trigger, so single-cycle events remain
// visible on an LED.
module led_stretch #(
  parameter int LED_STRETCH = 1_200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic led
);

  localparam int CW = $clog2(LED_STRETCH + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reload on every trigger, otherwise count down to zero and stop
  always_comb begin
    cnt_d = cnt_q;
    if (trig) begin
      cnt_d = CW'(LED_STRETCH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign led = (cnt_q != '0);

endmodule

// File: rtl/trace_tx_scheduler.sv
// Arbitrates the single UART TX byte stream between TPIU frames, host
// command replies and (optionally) periodic status packets, and owns the
// trace-width config register.
// Optional feature: define STATUS_INJECT_EN to enable the periodic status
// packet (A7, overflow count, width). Without it the STAT state is never
// entered and overflow strobes only drive the txOvf LED.
module trace_tx_scheduler
  import orbtrace_pkg::*;
#(
  parameter int FRAME_BYTES = 16,
  parameter int STAT_PERIOD = 12_000_000,
  parameter int LED_STRETCH = 1_200_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frameValid,
  input  logic [7:0]                     frameByte,
  output logic [$clog2(FRAME_BYTES)-1:0] frameIdx,
  output logic                           frameDone,
  input  logic                           cmdValid,
  input  logic [7:0]                     cmdByte,
  input  logic                           ovfIn,
  output logic [1:0]                     widthCfg,
  output logic [7:0]                     txData,
  output logic                           txValid,
  input  logic                           txReady,
  output logic                           txInd,
  output logic                           txOvf
);

  localparam int IDX_W = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  // Elaboration-time guard against unusable parameter sets
  if (FRAME_BYTES < 4 || FRAME_BYTES > 256 ||
      (FRAME_BYTES & (FRAME_BYTES - 1)) != 0 || STAT_PERIOD < 2) begin : g_cfg_check
    $error("trace_tx_scheduler: unsupported FRAME_BYTES or STAT_PERIOD");
  end

  state_t           state_q, state_d;
  state_t           pkt_q, pkt_d;        // payload state to enter once the header is sent
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [IDX_W-1:0] frame_idx_q, frame_idx_d;
  logic             frame_done_q, frame_done_d;
  logic [1:0]       width_q, width_d;
  logic             cmd_pend_q, cmd_pend_d;
  logic [7:0]       resp_byte_q, resp_byte_d;
  logic             tx_fire;

`ifdef STATUS_INJECT_EN
  localparam int TW = $clog2(STAT_PERIOD);
  localparam logic [TW-1:0] LAST_TICK = TW'(STAT_PERIOD - 1);

  logic          stat_pend_q, stat_pend_d;
  logic [TW-1:0] stat_timer_q, stat_timer_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic [7:0]    stat_ovf_q, stat_ovf_d;   // overflow count captured at header transfer
  logic          stat_sel_q, stat_sel_d;   // 0: count byte next, 1: width byte next
  logic          stat_clr;

  assign stat_clr = (state_q == ST_HDR) && (pkt_q == ST_STAT) && tx_fire;
`endif

  assign tx_fire = tx_valid_q && txReady;

  // Command intake, packet sequencing and byte presentation
  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    frame_idx_d  = frame_idx_q;
    frame_done_d = 1'b0;
    width_d      = width_q;
    cmd_pend_d   = cmd_pend_q;
    resp_byte_d  = resp_byte_q;
`ifdef STATUS_INJECT_EN
    stat_pend_d  = stat_pend_q;
    stat_timer_d = stat_timer_q;
    ovf_cnt_d    = ovf_cnt_q;
    stat_ovf_d   = stat_ovf_q;
    stat_sel_d   = stat_sel_q;
`endif

    // A command arriving while a reply is still owed is ignored outright
    if (cmdValid && !cmd_pend_q) begin
      cmd_pend_d = 1'b1;
      if (is_valid_set_width(cmdByte)) begin
        width_d     = cmdByte[1:0];
        resp_byte_d = {6'b0, cmdByte[1:0]};
      end else begin
        resp_byte_d = NAK;
      end
    end

    // Every payload state presents a byte whenever txValid is low, which
    // yields exactly one idle cycle after each accepted byte.
    case (state_q)
      ST_IDLE: begin
        if (cmd_pend_q) begin
          tx_data_d  = HDR_RESP;
          tx_valid_d = 1'b1;
          pkt_d      = ST_RESP;
          state_d    = ST_HDR;
        end else if (frameValid && !frame_done_q) begin
          // frame_done_q blocks re-sending a buffer that is still releasing
          tx_data_d  = HDR_FRAME;
          tx_valid_d = 1'b1;
          pkt_d      = ST_FRAME;
          state_d    = ST_HDR;
        end
`ifdef STATUS_INJECT_EN
        else if (stat_pend_q) begin
          tx_data_d  = HDR_STAT;
          tx_valid_d = 1'b1;
          pkt_d      = ST_STAT;
          state_d    = ST_HDR;
        end
`endif
      end

      ST_HDR: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = pkt_q;
        end
      end

      ST_FRAME: begin
        if (!tx_valid_q) begin
          tx_data_d  = frameByte;
          tx_valid_d = 1'b1;
        end else if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (frame_idx_q == LAST_IDX) begin
            frame_idx_d  = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            frame_idx_d = frame_idx_q + IDX_W'(1);
          end
        end
      end

      ST_RESP: begin
        if (!tx_valid_q) begin
          tx_data_d  = resp_byte_q;
          tx_valid_d = 1'b1;
        end else if (tx_fire) begin
          tx_valid_d = 1'b0;
          cmd_pend_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_STAT: begin
`ifdef STATUS_INJECT_EN
        if (!tx_valid_q) begin
          tx_data_d  = stat_sel_q ? {6'b0, width_q} : stat_ovf_q;
          tx_valid_d = 1'b1;
        end else if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (stat_sel_q) begin
            stat_sel_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            stat_sel_d = 1'b1;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

`ifdef STATUS_INJECT_EN
    // Overflow count: saturating, restarts at the STAT header transfer
    // (counting a coincident strobe)
    if (stat_clr) begin
      stat_ovf_d = ovf_cnt_q;
      stat_sel_d = 1'b0;
      ovf_cnt_d  = {7'b0, ovfIn};
    end else if (ovfIn && ovf_cnt_q != 8'hFF) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    // Free-running period timer; a new period end wins over the clear
    if (stat_timer_q == LAST_TICK) begin
      stat_timer_d = '0;
      stat_pend_d  = 1'b1;
    end else begin
      stat_timer_d = stat_timer_q + TW'(1);
      if (stat_clr) begin
        stat_pend_d = 1'b0;
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pkt_q        <= ST_IDLE;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      frame_idx_q  <= '0;
      frame_done_q <= 1'b0;
      width_q      <= WIDTH_1B;
      cmd_pend_q   <= 1'b0;
      resp_byte_q  <= 8'h00;
`ifdef STATUS_INJECT_EN
      stat_pend_q  <= 1'b0;
      stat_timer_q <= '0;
      ovf_cnt_q    <= 8'h00;
      stat_ovf_q   <= 8'h00;
      stat_sel_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      frame_idx_q  <= frame_idx_d;
      frame_done_q <= frame_done_d;
      width_q      <= width_d;
      cmd_pend_q   <= cmd_pend_d;
      resp_byte_q  <= resp_byte_d;
`ifdef STATUS_INJECT_EN
      stat_pend_q  <= stat_pend_d;
      stat_timer_q <= stat_timer_d;
      ovf_cnt_q    <= ovf_cnt_d;
      stat_ovf_q   <= stat_ovf_d;
      stat_sel_q   <= stat_sel_d;
`endif
    end
  end

  assign frameIdx  = frame_idx_q;
  assign frameDone = frame_done_q;
  assign widthCfg  = width_q;
  assign txData    = tx_data_q;
  assign txValid   = tx_valid_q;

  led_stretch #(.LED_STRETCH(LED_STRETCH)) u_led_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (tx_fire),
    .led   (txInd)
  );

  led_stretch #(.LED_STRETCH(LED_STRETCH)) u_led_ovf (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (ovfIn),
    .led   (txOvf)
  );

endmodule

// File: tb/tb_trace_tx_scheduler.sv
// Directed bench for trace_tx_scheduler: frame streaming, width commands,
// dropped commands, TX back-pressure, LED stretch, reset abort and (with
// STATUS_INJECT_EN) status packets.
module tb_trace_tx_scheduler;
  import orbtrace_pkg::*;

  localparam int FB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_valid;
  logic [7:0] frame_byte;
  logic [3:0] frame_idx;
  logic       frame_done;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       ovf_in;
  logic [1:0] width_cfg;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_ind;
  logic       tx_ovf;

  logic [7:0] fbuf [FB];
  logic [7:0] txq [$];
  int         done_cnt = 0;
  int         errors = 0;
  int         checks = 0;

  assign frame_byte = fbuf[frame_idx];

  always #5 clk = ~clk;

  trace_tx_scheduler #(
    .FRAME_BYTES (FB),
    .STAT_PERIOD (1000),
    .LED_STRETCH (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frameValid (frame_valid),
    .frameByte  (frame_byte),
    .frameIdx   (frame_idx),
    .frameDone  (frame_done),
    .cmdValid   (cmd_valid),
    .cmdByte    (cmd_byte),
    .ovfIn      (ovf_in),
    .widthCfg   (width_cfg),
    .txData     (tx_data),
    .txValid    (tx_valid),
    .txReady    (tx_ready),
    .txInd      (tx_ind),
    .txOvf      (tx_ovf)
  );

  // Record every accepted TX byte and every frameDone pulse
  always @(posedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles (to the falling edge); the frame buffer releases on frameDone
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (frame_done) frame_valid = 1'b0;
    end
  endtask

  // Wait until n bytes have been accepted, bounded by budget cycles
  task automatic wait_q(input int n, input int budget, input string tag);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(txq.size() >= n), 32'd1);
  endtask

  task automatic load_buf(input logic [7:0] base);
    for (int i = 0; i < FB; i++) fbuf[i] = base + 8'(i);
  endtask

  initial begin
    int b;
    int d0;
    int bad;
    rst_n = 1'b0; frame_valid = 1'b0; cmd_valid = 1'b0; cmd_byte = 8'h00;
    ovf_in = 1'b0; tx_ready = 1'b1;
    load_buf(8'h00);

    // Reset state
    cyc(2);
    chk("rst_frameIdx", 32'(frame_idx), 32'h0);
    chk("rst_frameDone", 32'(frame_done), 32'h0);
    chk("rst_widthCfg", 32'(width_cfg), 32'h0);
    chk("rst_txData", 32'(tx_data), 32'h00);
    chk("rst_txValid", 32'(tx_valid), 32'h0);
    chk("rst_txInd", 32'(tx_ind), 32'h0);
    chk("rst_txOvf", 32'(tx_ovf), 32'h0);
    rst_n = 1'b1;

    // 1. Plain frame 00..0F
    b = txq.size(); d0 = done_cnt;
    frame_valid = 1'b1;
    wait_q(b + 16, 100, "t1_wait16");
    chk("t1_no_early_done", 32'(done_cnt - d0), 32'd0);
    wait_q(b + 17, 10, "t1_wait17");
    chk("t1_done_after_last", 32'(frame_done), 32'h1);
    chk("t1_frameIdx_wrap", 32'(frame_idx), 32'h0);
    chk("t1_hdr", 32'(txq[b]), 32'hA5);
    for (int i = 0; i < FB; i++) chk($sformatf("t1_byte%0d", i), 32'(txq[b + 1 + i]), 32'(i));
    cyc(5);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_no_resend", 32'(txq.size()), 32'(b + 17));

    // 2. SET_WIDTH 2 mid-frame
    b = txq.size(); load_buf(8'h10); frame_valid = 1'b1;
    wait_q(b + 5, 100, "t2_wait_mid");
    cmd_valid = 1'b1; cmd_byte = 8'h52;
    chk("t2_width_before", 32'(width_cfg), 32'h0);
    cyc(1);
    cmd_valid = 1'b0;
    chk("t2_width_after", 32'(width_cfg), 32'h2);
    wait_q(b + 19, 300, "t2_wait_all");
    chk("t2_hdr", 32'(txq[b]), 32'hA5);
    chk("t2_last", 32'(txq[b + 16]), 32'h1F);
    chk("t2_resp_hdr", 32'(txq[b + 17]), 32'hA6);
    chk("t2_resp_w", 32'(txq[b + 18]), 32'h02);

    // 3. Invalid width, then a command dropped while pending
    b = txq.size();
    cmd_valid = 1'b1; cmd_byte = 8'h53;
    cyc(1);
    cmd_byte = 8'h51;
    cyc(1);
    cmd_valid = 1'b0;
    wait_q(b + 2, 50, "t3_wait");
    cyc(20);
    chk("t3_one_reply", 32'(txq.size()), 32'(b + 2));
    chk("t3_hdr", 32'(txq[b]), 32'hA6);
    chk("t3_nak", 32'(txq[b + 1]), 32'hFF);
    chk("t3_width_kept", 32'(width_cfg), 32'h2);
    chk("t3_txInd_off", 32'(tx_ind), 32'h0);

    // 4. Back-pressure on byte 3
    b = txq.size(); load_buf(8'h20); frame_valid = 1'b1;
    wait_q(b + 4, 100, "t4_wait_b2");
    tx_ready = 1'b0;
    cyc(1);
    chk("t4_stall_valid", 32'(tx_valid), 32'h1);
    chk("t4_stall_data", 32'(tx_data), 32'h23);
    chk("t4_stall_idx", 32'(frame_idx), 32'h3);
    chk("t4_txInd_on", 32'(tx_ind), 32'h1);
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      cyc(1);
      if (tx_valid !== 1'b1 || tx_data !== 8'h23) bad++;
    end
    chk("t4_stable", 32'(bad), 32'd0);
    chk("t4_txInd_expired", 32'(tx_ind), 32'h0);
    tx_ready = 1'b1;
    wait_q(b + 17, 100, "t4_wait_all");
    chk("t4_b3", 32'(txq[b + 4]), 32'h23);
    chk("t4_b4", 32'(txq[b + 5]), 32'h24);
    chk("t4_last", 32'(txq[b + 16]), 32'h2F);
    cyc(3);

    // Overflow LED stretch
    ovf_in = 1'b1;
    cyc(1);
    ovf_in = 1'b0;
    chk("ovf_led_on", 32'(tx_ovf), 32'h1);
    cyc(10);
    chk("ovf_led_off", 32'(tx_ovf), 32'h0);

    // 6. Reset at byte 7, then restart from the header
    b = txq.size(); load_buf(8'h30); frame_valid = 1'b1;
    wait_q(b + 8, 100, "t6_wait_b6");
    cyc(1);
    chk("t6_at_byte7", 32'(frame_idx), 32'h7);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_valid), 32'h0);
    chk("t6_rst_data", 32'(tx_data), 32'h00);
    chk("t6_rst_idx", 32'(frame_idx), 32'h0);
    chk("t6_rst_width", 32'(width_cfg), 32'h0);
    chk("t6_rst_ind", 32'(tx_ind), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    b = txq.size();
    wait_q(b + 17, 100, "t6_wait_all");
    chk("t6_hdr", 32'(txq[b]), 32'hA5);
    chk("t6_b0", 32'(txq[b + 1]), 32'h30);
    chk("t6_b7", 32'(txq[b + 8]), 32'h37);
    chk("t6_last", 32'(txq[b + 16]), 32'h3F);

`ifdef STATUS_INJECT_EN
    // 5. Status packets: saturated count, then a strobe on the clear cycle
    cyc(2);
    ovf_in = 1'b1;
    cyc(300);
    ovf_in = 1'b0;
    chk("t5_txOvf", 32'(tx_ovf), 32'h1);
    b = txq.size();
    wait_q(b + 3, 1200, "t5_wait_stat1");
    chk("t5_hdr", 32'(txq[b]), 32'hA7);
    chk("t5_sat", 32'(txq[b + 1]), 32'hFF);
    chk("t5_width", 32'(txq[b + 2]), 32'h00);
    bad = 1;
    for (int k = 0; k < 1200 && bad != 0; k++) begin
      cyc(1);
      if (tx_valid && tx_ready && tx_data == 8'hA7) begin
        b = txq.size();
        ovf_in = 1'b1;
        cyc(1);
        ovf_in = 1'b0;
        bad = 0;
      end
    end
    chk("t5_found_hdr2", 32'(bad), 32'd0);
    wait_q(b + 3, 50, "t5_wait_stat2");
    chk("t5_stat2_cnt", 32'(txq[b + 1]), 32'h00);
    b = txq.size();
    wait_q(b + 3, 1200, "t5_wait_stat3");
    chk("t5_stat3_hdr", 32'(txq[b]), 32'hA7);
    chk("t5_stat3_cnt", 32'(txq[b + 1]), 32'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
